// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one start/done ALU between two requesters
module alu_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_result,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_result,
    output logic        rsp1_err,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nx;
    logic        rr_ptr;
    logic        id;
    logic [TW-1:0] timer;
    logic [15:0] result;
    logic        err;

    logic        grant, grant_any, accept, is_alu, timeout;
    logic [2:0]  acc_op;
    logic [7:0]  acc_a, acc_b;

    // Contention goes to rr_ptr; a lone requester is served regardless of rr_ptr.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        req0_ready = (state == IDLE) && grant_any && !grant;
        req1_ready = (state == IDLE) && grant_any && grant;
        accept     = req0_ready | req1_ready;
        acc_op     = grant ? req1_op : req0_op;
        acc_a      = grant ? req1_a  : req0_a;
        acc_b      = grant ? req1_b  : req0_b;
        is_alu     = (acc_op != 3'd0) && (acc_op <= 3'd4);
        timeout    = (state == BUSY) && !alu_done && (timer == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = is_alu ? BUSY : RESP;
            BUSY:    if (alu_done || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= 1'b0;
            id        <= 1'b0;
            timer     <= '0;
            result    <= '0;
            err       <= 1'b0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id     <= grant;
                        rr_ptr <= ~grant;
                        if (is_alu) begin
                            alu_start <= 1'b1;
                            alu_op    <= acc_op;
                            alu_a     <= acc_a;
                            alu_b     <= acc_b;
                        end else begin
                            result <= '0;
                            err    <= (acc_op > 3'd4);
                        end
                    end
                end
                BUSY: begin
                    timer <= timer + 1'b1;
                    // done takes priority over a coincident timeout
                    if (alu_done) begin
                        result    <= alu_result;
                        err       <= 1'b0;
                        alu_start <= 1'b0;
                    end else if (timeout) begin
                        result    <= '0;
                        err       <= 1'b1;
                        alu_start <= 1'b0;
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

    always_comb begin
        rsp0_valid  = (state == RESP) && !id;
        rsp1_valid  = (state == RESP) && id;
        rsp0_result = rsp0_valid ? result : 16'h0;
        rsp0_err    = rsp0_valid & err;
        rsp1_result = rsp1_valid ? result : 16'h0;
        rsp1_err    = rsp1_valid & err;
        busy        = (state != IDLE);
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a start/done ALU model
module tb_alu_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [15:0] rsp0_result, rsp1_result;
    logic        alu_start, alu_done, busy;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_result;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
    );

    typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; } req_t;
    typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [2:0] op;
                     logic [15:0] result; logic err; int lat; int acc; } sb_t;

    req_t q0[$], q1[$];
    sb_t  sb[$];
    int   grants[$];
    int   pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int   cyc = 0, start_cycles = 0, alu_cnt;
    logic hang = 1'b0;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALU model: add/and/xor done one cycle after start is seen, mul after three
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_done <= 1'b0; alu_result <= 16'h0; alu_cnt <= 0;
        end else begin
            alu_done <= 1'b0;
            if (alu_start && !alu_done && !hang) begin
                if (alu_cnt + 1 >= ((alu_op == 3'd4) ? 3 : 1)) begin
                    alu_done <= 1'b1; alu_result <= alu_fn(alu_op, alu_a, alu_b); alu_cnt <= 0;
                end else alu_cnt <= alu_cnt + 1;
            end else if (!alu_start) alu_cnt <= 0;
        end
    end

    always @(posedge clk) cyc++;

    task automatic expect_op(input int id, input req_t r);
        sb_t e;
        e.id = id; e.a = r.a; e.b = r.b; e.op = r.op; e.acc = cyc;
        if (r.op >= 3'd1 && r.op <= 3'd4) begin
            e.result = hang ? 16'h0 : alu_fn(r.op, r.a, r.b);
            e.err    = hang;
            e.lat    = hang ? TIMEOUT + 1 : ((r.op == 3'd4) ? 5 : 3);
        end else begin
            e.result = 16'h0; e.err = (r.op > 3'd4); e.lat = 1;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("invariants", {req0_ready & req1_ready, rsp0_valid & rsp1_valid,
                               rsp0_valid ? 17'h0 : {rsp0_result, rsp0_err},
                               rsp1_valid ? 17'h0 : {rsp1_result, rsp1_err},
                               (rsp0_valid | rsp1_valid) & alu_start, alu_start & ~busy}, 64'h0);
            if (alu_start) start_cycles++;
            if (alu_start && sb.size() > 0)
                chk("alu_inputs", {alu_op, alu_a, alu_b}, {sb[0].op, sb[0].a, sb[0].b});
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("rsp_id", rsp1_valid ? 1 : 0, e.id);
                    chk("rsp_result", rsp1_valid ? rsp1_result : rsp0_result, e.result);
                    chk("rsp_err", rsp1_valid ? rsp1_err : rsp0_err, e.err);
                    chk("rsp_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Presents queue heads as requests until every queued op is accepted and answered.
    task automatic run();
        int budget = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && budget < 400) begin
            @(negedge clk);
            budget++;
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op; end
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op; end
            #1;
            if (req0_valid && req0_ready) begin expect_op(0, q0[0]); void'(q0.pop_front()); grants.push_back(0); end
            if (req1_valid && req1_ready) begin expect_op(1, q1[0]); void'(q1.pop_front()); grants.push_back(1); end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("run_budget", budget < 400, 1);
    endtask

    function automatic logic [15:0] gnt_pat();
        logic [7:0] p = 8'h0;
        foreach (grants[i]) if (i < 8) p[i] = grants[i][0];
        return {8'(grants.size()), p};
    endfunction

    initial begin
        int s;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, alu_start, alu_op, alu_a, alu_b, rsp0_valid, rsp0_result, rsp0_err,
                              rsp1_valid, rsp1_result, rsp1_err}, 64'h0);
        reset_n = 1'b1;

        q0.push_back(req_t'{a: 8'hFF, b: 8'h01, op: 3'd1});
        run();

        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        grants.delete();
        q0.push_back(req_t'{a: 8'hFF, b: 8'hFF, op: 3'd4});
        q1.push_back(req_t'{a: 8'hAA, b: 8'h55, op: 3'd3});
        run();
        chk("t2_grant_order", gnt_pat(), {8'd2, 8'b10});

        grants.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(req_t'{a: 8'($urandom), b: 8'($urandom), op: 3'(i + 1)});
            q1.push_back(req_t'{a: 8'($urandom), b: 8'($urandom), op: 3'(4 - i)});
        end
        run();
        chk("t3_alternation", gnt_pat(), {8'd6, 8'b101010});

        s = start_cycles;
        q1.push_back(req_t'{a: 8'h12, b: 8'h34, op: 3'd0});
        run();
        q0.push_back(req_t'{a: 8'h56, b: 8'h78, op: 3'd7});
        run();
        chk("t4_no_alu_start", start_cycles - s, 0);

        hang = 1'b1;
        s = start_cycles;
        q0.push_back(req_t'{a: 8'h03, b: 8'h04, op: 3'd1});
        run();
        chk("t5_start_cycles", start_cycles - s, TIMEOUT);
        hang = 1'b0;
        q0.push_back(req_t'{a: 8'h12, b: 8'h34, op: 3'd1});
        run();

        @(negedge clk);
        req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 3'd4; req0_valid = 1'b1;
        #1 chk("t6_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t6_start", alu_start, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t6_async_reset", {alu_start, busy}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        grants.delete();
        q0.push_back(req_t'{a: 8'h01, b: 8'h02, op: 3'd1});
        q1.push_back(req_t'{a: 8'hF0, b: 8'h3C, op: 3'd2});
        run();
        chk("t6_grant_after_reset", gnt_pat(), {8'd2, 8'b10});

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
